// File: rtl/rabin_pkg.sv
// rtl/rabin_pkg.sv - Rabin fingerprint defaults and GF(2) polynomial helpers
// Constant functions are shared by the engine and its elaboration-time tables.
package rabin_pkg;

  localparam int          DEF_WINDOW = 48;
  localparam logic [63:0] DEF_POLY   = 64'hbfe6b8a5bf378d83;

  function automatic logic [63:0] gf_mulx8(input logic [63:0] t_in,
                                           input logic [7:0]  b,
                                           input logic [63:0] poly);
    logic [63:0] t;
    logic        m;
    t = t_in;
    for (int k = 0; k < 8; k++) begin
      m = t[63];
      t = t << 1;
      if (m) t = t ^ poly;
    end
    return t ^ {56'b0, b};
  endfunction

  // x^(8*window+i) mod P: weight of bit i of the byte leaving the window
  function automatic logic [63:0] out_const(input int i,
                                            input int window,
                                            input logic [63:0] poly);
    logic [63:0] t;
    logic        m;
    t = 64'h1;
    for (int n = 0; n < 8 * window + i; n++) begin
      m = t[63];
      t = t << 1;
      if (m) t = t ^ poly;
    end
    return t;
  endfunction

endpackage

// File: rtl/rabin_window.sv
// rtl/rabin_window.sv - byte delay line returning the byte inserted DEPTH shifts ago
module rabin_window #(
  parameter int DEPTH = 48
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] din,
  input  logic       shift_en,
  output logic [7:0] dout_old
);

  logic [7:0] sr_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= 8'h00;
    end else if (shift_en) begin
      sr_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_old = sr_q[DEPTH-1];

endmodule

// File: rtl/rabin_fingerprint.sv
// rtl/rabin_fingerprint.sv - rolling Rabin fingerprint over a popped byte stream
// Optional breakpoint strobe enabled by defining RABIN_BREAK_EN.
module rabin_fingerprint
  import rabin_pkg::*;
#(
  parameter int          WINDOW = DEF_WINDOW,
  parameter logic [63:0] POLY   = DEF_POLY
`ifdef RABIN_BREAK_EN
  , parameter int                    BREAK_BITS = 12
  , parameter logic [BREAK_BITS-1:0] BREAK_VAL  = 12'h078
`endif
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  din,
  input  logic        empty,
  output logic        pop,
  output logic [63:0] dout,
  output logic        dout_valid,
  output logic        dout_break
);

  logic [63:0] fp_q, fp_d;
  logic        valid_q;
  logic [7:0]  old_byte;
  logic [63:0] k_tab [8];
  logic [63:0] rem;

  assign pop = !wb_rst_i && !empty;

  rabin_window #(.DEPTH(WINDOW)) u_window (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .din      (din),
    .shift_en (pop),
    .dout_old (old_byte)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_ktab
    localparam logic [63:0] KI = out_const(gi, WINDOW, POLY);
    assign k_tab[gi] = KI;
  end

  always_comb begin
    rem = '0;
    for (int i = 0; i < 8; i++) begin
      if (old_byte[i]) rem = rem ^ k_tab[i];
    end
    fp_d = gf_mulx8(fp_q, din, POLY) ^ rem;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      fp_q    <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      fp_q    <= fp_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

`ifdef RABIN_BREAK_EN
  logic break_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) break_q <= 1'b0;
    else          break_q <= pop && (fp_d[BREAK_BITS-1:0] == BREAK_VAL);
  end
  assign dout_break = break_q;
`else
  assign dout_break = 1'b0;
`endif

  assign dout       = fp_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_rabin_fingerprint.sv
// tb/tb_rabin_fingerprint.sv - directed vector bench for rabin_fingerprint
module tb_rabin_fingerprint;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        empty;
  logic        pop;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_break;

  int n_vec = 0;
  int n_err = 0;

`ifdef RABIN_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  rabin_fingerprint dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .din        (din),
    .empty      (empty),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_break (dout_break)
  );

  typedef struct {
    logic        rst;
    logic        emp;
    logic [7:0]  d;
    logic        e_pop;
    logic        e_val;
    logic        e_brk;
    logic [63:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic [7:0] d, logic p,
                              logic v, logic b, logic [63:0] o);
    vec_t x;
    x.rst = r; x.emp = e; x.d = d; x.e_pop = p; x.e_val = v; x.e_brk = b; x.e_dout = o;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive on the falling edge, sample pop before the rising edge and registers just after it
  task automatic step(input logic r, input logic e, input logic [7:0] d,
                      output logic p, output logic v, output logic b, output logic [63:0] o);
    @(negedge clk);
    rst = r; empty = e; din = d;
    #1 p = pop;
    @(posedge clk);
    #1;
    v = dout_valid; b = dout_break; o = dout;
  endtask

  logic        p, v, b;
  logic [63:0] o;
  logic [7:0]  common [48];
  logic [7:0]  pre    [77];
  logic [7:0]  strm   [20];
  logic [63:0] r_fresh, r_a, r_b, r_gapless, r_mid;

  task automatic feed(input logic [7:0] d);
    step(1'b0, 1'b0, d, p, v, b, o);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 8'h00, p, v, b, o);
  endtask

  initial begin
    rst = 1'b1; empty = 1'b1; din = 8'h00;
    for (int i = 0; i < 48; i++) common[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 77; i++) pre[i]    = 8'($urandom_range(0, 255));
    for (int i = 0; i < 20; i++) strm[i]   = 8'($urandom_range(0, 255));

    tbl.push_back(mk(1, 1, 8'h00, 0, 0, 0, 64'h0));
    tbl.push_back(mk(1, 0, 8'hff, 0, 0, 0, 64'h0));
    tbl.push_back(mk(0, 0, 8'h01, 1, 1, 0, 64'h1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h100));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 64'h100));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h10000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h1000000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h100000000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h10000000000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h1000000000000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h0100000000000000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'hbfe6b8a5bf378d83));
    tbl.push_back(mk(1, 0, 8'h33, 0, 0, 0, 64'h0));
    tbl.push_back(mk(0, 0, 8'h05, 1, 1, 0, 64'h5));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 64'h5));
    tbl.push_back(mk(1, 1, 8'h00, 0, 0, 0, 64'h0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 64'h0));
    tbl.push_back(mk(0, 0, 8'h78, 1, 1, BRK_EN, 64'h78));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 64'h78));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].emp, tbl[i].d, p, v, b, o);
      chk($sformatf("vec%0d_pop", i),   {63'b0, p}, {63'b0, tbl[i].e_pop});
      chk($sformatf("vec%0d_valid", i), {63'b0, v}, {63'b0, tbl[i].e_val});
      chk($sformatf("vec%0d_break", i), {63'b0, b}, {63'b0, tbl[i].e_brk});
      chk($sformatf("vec%0d_dout", i),  o,          tbl[i].e_dout);
    end

    // fingerprint depends only on the last window bytes
    do_reset();
    for (int i = 0; i < 48; i++) feed(common[i]);
    r_fresh = o;
    chk("fresh_valid", {63'b0, v}, 64'h1);
    do_reset();
    for (int i = 0; i < 10; i++) feed(pre[i]);
    for (int i = 0; i < 48; i++) feed(common[i]);
    r_a = o;
    do_reset();
    for (int i = 0; i < 77; i++) feed(pre[i]);
    for (int i = 0; i < 48; i++) feed(common[i]);
    r_b = o;
    chk("prefix10_vs_prefix77", r_a, r_b);
    chk("prefix10_vs_fresh", r_a, r_fresh);

    // empty gap must freeze state and leave the result identical to a gapless run
    do_reset();
    for (int i = 0; i < 20; i++) begin
      feed(strm[i]);
      if (i == 7) r_mid = o;
    end
    r_gapless = o;
    do_reset();
    for (int i = 0; i < 8; i++) feed(strm[i]);
    chk("pre_gap_dout", o, r_mid);
    for (int g = 0; g < 5; g++) begin
      step(1'b0, 1'b1, 8'hee, p, v, b, o);
      chk($sformatf("gap%0d_pop", g),   {63'b0, p}, 64'h0);
      chk($sformatf("gap%0d_valid", g), {63'b0, v}, 64'h0);
      chk($sformatf("gap%0d_dout", g),  o, r_mid);
    end
    for (int i = 8; i < 20; i++) feed(strm[i]);
    chk("gap_vs_gapless", o, r_gapless);
    chk("gap_end_valid", {63'b0, v}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
